// File: rtl/maze_dfs_solver.sv
// ---------------------------------------------------------------------------
// maze_dfs_solver : depth-first grid maze solver with explicit backtrack stack
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module maze_dfs_solver #(
  parameter int COLS = 17,
  parameter int ROWS = 17,
  parameter int XW   = $clog2(COLS),
  parameter int YW   = $clog2(ROWS),
  parameter int LW   = $clog2(COLS*ROWS+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [XW-1:0]        start_x,
  input  logic [YW-1:0]        start_y,
  input  logic [XW-1:0]        end_x,
  input  logic [YW-1:0]        end_y,
  input  logic [COLS*ROWS-1:0] maze,
  output logic                 busy,
  output logic                 done,
  output logic                 found,
  output logic [COLS*ROWS-1:0] path,
  output logic [LW-1:0]        path_len,
  output logic [31:0]          cycles
);

  localparam int N   = COLS * ROWS;
  localparam int IW  = $clog2(N);
  localparam int SIW = $clog2(N - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CHECK   = 2'd1,
    S_EXPLORE = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    maze_q, maze_d;
  logic [N-1:0]    visited_q, visited_d;
  logic [N-1:0]    path_q, path_d;
  logic [XW-1:0]   sx_q, sx_d, ex_q, ex_d, cx_q, cx_d;
  logic [YW-1:0]   sy_q, sy_d, ey_q, ey_d, cy_q, cy_d;
  logic [LW-1:0]   len_q, len_d;
  logic [31:0]     cycles_q, cycles_d;
  logic            found_q, found_d;
  logic [IW-1:0]   sp_q, sp_d;
  logic [1:0]      stack_q [N-1];

  logic            push_en;
  logic [1:0]      push_dir;
  logic [1:0]      pop_dir;
  logic [IW-1:0]   cur_idx, s_idx, g_idx;
  logic [IW-1:0]   nb_idx [4];
  logic [3:0]      can_mv;
  logic            mv_ok;
  logic [1:0]      mv_dir;
  logic            coords_ok;

  function automatic logic [IW-1:0] cell_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return IW'(y) * IW'(COLS) + IW'(x);
  endfunction

  assign cur_idx   = cell_idx(cx_q, cy_q);
  assign s_idx     = cell_idx(sx_q, sy_q);
  assign g_idx     = cell_idx(ex_q, ey_q);
  assign coords_ok = (sx_q <= XW'(COLS-1)) && (sy_q <= YW'(ROWS-1)) &&
                     (ex_q <= XW'(COLS-1)) && (ey_q <= YW'(ROWS-1));

  // Neighbour order right, down, left, up matches the 2-bit direction code.
  assign nb_idx[0] = cur_idx + IW'(1);
  assign nb_idx[1] = cur_idx + IW'(COLS);
  assign nb_idx[2] = cur_idx - IW'(1);
  assign nb_idx[3] = cur_idx - IW'(COLS);

  assign can_mv[0] = (cx_q != XW'(COLS-1)) && maze_q[nb_idx[0]] && !visited_q[nb_idx[0]];
  assign can_mv[1] = (cy_q != YW'(ROWS-1)) && maze_q[nb_idx[1]] && !visited_q[nb_idx[1]];
  assign can_mv[2] = (cx_q != '0)          && maze_q[nb_idx[2]] && !visited_q[nb_idx[2]];
  assign can_mv[3] = (cy_q != '0)          && maze_q[nb_idx[3]] && !visited_q[nb_idx[3]];

  assign mv_ok   = |can_mv;
  assign mv_dir  = can_mv[0] ? 2'd0 : can_mv[1] ? 2'd1 : can_mv[2] ? 2'd2 : 2'd3;
  assign pop_dir = stack_q[SIW'(sp_q - IW'(1))];

  always_comb begin
    state_d   = state_q;
    maze_d    = maze_q;
    visited_d = visited_q;
    path_d    = path_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    ex_d      = ex_q;
    ey_d      = ey_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    len_d     = len_q;
    cycles_d  = cycles_q;
    found_d   = found_q;
    sp_d      = sp_q;
    push_en   = 1'b0;
    push_dir  = 2'd0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          maze_d    = maze;
          sx_d      = start_x;
          sy_d      = start_y;
          ex_d      = end_x;
          ey_d      = end_y;
          visited_d = '0;
          path_d    = '0;
          len_d     = '0;
          cycles_d  = '0;
          found_d   = 1'b0;
          sp_d      = '0;
          state_d   = S_CHECK;
        end
      end

      S_CHECK: begin
        if (!coords_ok || !maze_q[s_idx] || !maze_q[g_idx]) begin
          state_d = S_FINISH;
        end else if (s_idx == g_idx) begin
          path_d[s_idx] = 1'b1;
          len_d         = LW'(1);
          found_d       = 1'b1;
          state_d       = S_FINISH;
        end else begin
          visited_d[s_idx] = 1'b1;
          path_d[s_idx]    = 1'b1;
          len_d            = LW'(1);
          sp_d             = '0;
          cx_d             = sx_q;
          cy_d             = sy_q;
          state_d          = S_EXPLORE;
        end
      end

      S_EXPLORE: begin
        cycles_d = cycles_q + 32'd1;
        if ((cx_q == ex_q) && (cy_q == ey_q)) begin
          found_d = 1'b1;
          state_d = S_FINISH;
        end else if (mv_ok) begin
          push_en                   = 1'b1;
          push_dir                  = mv_dir;
          sp_d                      = sp_q + IW'(1);
          visited_d[nb_idx[mv_dir]] = 1'b1;
          path_d[nb_idx[mv_dir]]    = 1'b1;
          len_d                     = len_q + LW'(1);
          case (mv_dir)
            2'd0:    cx_d = cx_q + XW'(1);
            2'd1:    cy_d = cy_q + YW'(1);
            2'd2:    cx_d = cx_q - XW'(1);
            default: cy_d = cy_q - YW'(1);
          endcase
        end else if (sp_q != '0) begin
          // Backtrack: undo the move that entered this cell; visited stays set.
          sp_d            = sp_q - IW'(1);
          path_d[cur_idx] = 1'b0;
          len_d           = len_q - LW'(1);
          case (pop_dir)
            2'd0:    cx_d = cx_q - XW'(1);
            2'd1:    cy_d = cy_q - YW'(1);
            2'd2:    cx_d = cx_q + XW'(1);
            default: cy_d = cy_q + YW'(1);
          endcase
        end else begin
          found_d = 1'b0;
          path_d  = '0;
          len_d   = '0;
          state_d = S_FINISH;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      maze_q    <= '0;
      visited_q <= '0;
      path_q    <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      ex_q      <= '0;
      ey_q      <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      len_q     <= '0;
      cycles_q  <= '0;
      found_q   <= 1'b0;
      sp_q      <= '0;
      for (int i = 0; i < N - 1; i++) begin
        stack_q[i] <= 2'd0;
      end
    end else begin
      state_q   <= state_d;
      maze_q    <= maze_d;
      visited_q <= visited_d;
      path_q    <= path_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      ex_q      <= ex_d;
      ey_q      <= ey_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      len_q     <= len_d;
      cycles_q  <= cycles_d;
      found_q   <= found_d;
      sp_q      <= sp_d;
      if (push_en) begin
        stack_q[SIW'(sp_q)] <= push_dir;
      end
    end
  end

  assign busy     = (state_q == S_CHECK) || (state_q == S_EXPLORE);
  assign done     = (state_q == S_FINISH);
  assign found    = found_q;
  assign path     = path_q;
  assign path_len = len_q;
  assign cycles   = cycles_q;

endmodule

`default_nettype wire

// File: tb/tb_maze_dfs_solver.sv
// ---------------------------------------------------------------------------
// tb_maze_dfs_solver : directed self-checking bench, 3x3 and 17x17 instances
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_maze_dfs_solver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        st3, busy3, done3, found3;
  logic [1:0]  sx3, sy3, ex3, ey3;
  logic [8:0]  mz3, path3;
  logic [3:0]  len3;
  logic [31:0] cyc3;

  logic         st17, busy17, done17, found17;
  logic [4:0]   sx17, sy17, ex17, ey17;
  logic [288:0] mz17, path17, exp17;
  logic [8:0]   len17;
  logic [31:0]  cyc17;

  int total = 0;
  int bad   = 0;

  maze_dfs_solver #(.COLS(3), .ROWS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(st3),
    .start_x(sx3), .start_y(sy3), .end_x(ex3), .end_y(ey3), .maze(mz3),
    .busy(busy3), .done(done3), .found(found3),
    .path(path3), .path_len(len3), .cycles(cyc3)
  );

  maze_dfs_solver #(.COLS(17), .ROWS(17)) u_dut17 (
    .clk(clk), .rst_n(rst_n), .start(st17),
    .start_x(sx17), .start_y(sy17), .end_x(ex17), .end_y(ey17), .maze(mz17),
    .busy(busy17), .done(done17), .found(found17),
    .path(path17), .path_len(len17), .cycles(cyc17)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run3(input string tag, input logic [8:0] m,
                      input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] c, input logic [1:0] d,
                      input logic ef, input logic [8:0] ep,
                      input logic [3:0] el, input int ec, input int elat);
    int lat;
    lat = 0;
    @(negedge clk);
    mz3 = m; sx3 = a; sy3 = b; ex3 = c; ey3 = d; st3 = 1'b1;
    @(posedge clk); #1;
    st3 = 1'b0;
    check({tag, " busy"}, 512'(busy3), 512'(1));
    // Scramble the live inputs; the solver must work from its latched copies.
    mz3 = ~m; sx3 = c; sy3 = d; ex3 = a; ey3 = b;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done3) begin
        lat = k + 1;
        break;
      end
    end
    check({tag, " latency"}, 512'(lat), 512'(elat));
    @(posedge clk); #1;
    check({tag, " done/busy drop"}, 512'({done3, busy3}), 512'(0));
    check({tag, " found"}, 512'(found3), 512'(ef));
    check({tag, " path"}, 512'(path3), 512'(ep));
    check({tag, " len"}, 512'(len3), 512'(el));
    check({tag, " cycles"}, 512'(cyc3), 512'(ec));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, evts;
    rst_n = 1'b0;
    st3 = 1'b0; sx3 = '0; sy3 = '0; ex3 = '0; ey3 = '0; mz3 = '0;
    st17 = 1'b0; sx17 = '0; sy17 = '0; ex17 = '0; ey17 = '0; mz17 = '0;
    exp17 = '0;
    for (int i = 0; i < 17; i++) exp17[i] = 1'b1;
    for (int y = 0; y < 17; y++) exp17[y*17+16] = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset ctl3", 512'({busy3, done3, found3, len3, cyc3}), 512'(0));
    check("reset path3", 512'(path3), 512'(0));
    check("reset ctl17", 512'({busy17, done17, found17, len17, cyc17}), 512'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run3("open",    9'h1FF, 2'd0, 2'd0, 2'd2, 2'd2, 1'b1, 9'h127, 4'd5, 5, 7);
    run3("dead",    9'h1CB, 2'd0, 2'd0, 2'd2, 2'd2, 1'b1, 9'h1C9, 4'd5, 7, 9);
    run3("goalwal", 9'h0FF, 2'd0, 2'd0, 2'd2, 2'd2, 1'b0, 9'h000, 4'd0, 0, 2);
    run3("boxed",   9'h1F5, 2'd0, 2'd0, 2'd2, 2'd2, 1'b0, 9'h000, 4'd0, 1, 3);
    run3("oob",     9'h1FF, 2'd3, 2'd0, 2'd2, 2'd2, 1'b0, 9'h000, 4'd0, 0, 2);
    run3("same",    9'h1FF, 2'd1, 2'd1, 2'd1, 2'd1, 1'b1, 9'h010, 4'd1, 0, 2);

    // 17x17 open grid with a second start pulse while busy.
    @(negedge clk);
    mz17 = '1; sx17 = 5'd0; sy17 = 5'd0; ex17 = 5'd16; ey17 = 5'd16; st17 = 1'b1;
    @(posedge clk); #1;
    st17 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (k == 3) st17 = 1'b1;
      if (k == 4) st17 = 1'b0;
      if (done17) begin
        lat = k + 1;
        break;
      end
    end
    check("big latency", 512'(lat), 512'(35));
    check("big found", 512'(found17), 512'(1));
    check("big len", 512'(len17), 512'(33));
    check("big cycles", 512'(cyc17), 512'(33));
    check("big path", 512'(path17), 512'(exp17));
    evts = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done17 || busy17) evts++;
    end
    check("big no retrigger", 512'(evts), 512'(0));

    // Abort mid-solve with reset.
    @(negedge clk);
    st17 = 1'b1;
    @(posedge clk); #1;
    st17 = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    check("abort busy before", 512'(busy17), 512'(1));
    rst_n = 1'b0;
    #1;
    check("abort ctl", 512'({busy17, done17, found17, len17, cyc17}), 512'(0));
    check("abort path", 512'(path17), 512'(0));
    evts = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done17) evts++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (done17 || busy17) evts++;
    end
    check("abort no done", 512'(evts), 512'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/maze_dfs_solver.md
Name: maze_dfs_solver

Overview:
- Parametrised depth-first maze solver with explicit backtrack stack and runtime-programmable start/end coordinates.
- Accepts a flattened occupancy map and a start pulse, then walks the grid one move per cycle.
- Reports a found/no-path result, the exact path mask, path length and cycle count.
- Sits beside the maze generator/loader and feeds the path display and scoreboard logic.

Parameters:
- COLS, 17, maze width in cells (>=2)
- ROWS, 17, maze height in cells (>=2)
- XW, clog2(COLS), x coordinate width
- YW, clog2(ROWS), y coordinate width
- LW, clog2(COLS*ROWS+1), path length width

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- start_x  input  XW  start column
- start_y  input  YW  start row
- end_x  input  XW  goal column
- end_y  input  YW  goal row
- maze  input  COLS*ROWS  1=open, 0=wall; cell (x,y) at bit y*COLS+x
- busy  output  1  high from start acceptance until done
- done  output  1  one-cycle completion pulse
- found  output  1  result valid after done: 1=path exists
- path  output  COLS*ROWS  path cell mask, same indexing as maze
- path_len  output  LW  cells on path including start and goal
- cycles  output  32  cycles spent in EXPLORE for last solve

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, found=0, path=0, path_len=0, cycles=0; visited and stack cleared.
- States: IDLE, CHECK, EXPLORE, FINISH.
- IDLE + start=1: latch maze and all coordinates; clear visited, path, path_len, cycles, found; busy=1; go to CHECK.
  - start is level-sampled; held high, it retriggers only after returning to IDLE.
- CHECK (1 cycle):
  - Out-of-range coordinate, or start/goal cell is a wall: found=0 and go to FINISH.
  - Start equals goal: set path bit, path_len=1, found=1, go to FINISH.
  - Otherwise: mark start visited and on path, path_len=1, stack pointer sp=0, go to EXPLORE.
- EXPLORE (one action per cycle, cycles+1 each cycle):
  - If current cell equals goal: found=1, go to FINISH.
  - Else forward move to the first in-bounds, open, unvisited neighbour in the order right(x+1), down(y+1), left(x-1), up(y-1).
    - Push the 2-bit direction, mark the new cell visited and on path, path_len+1.
  - Else, if sp>0, backtrack: pop the direction, clear the current cell's path bit, move opposite, path_len-1.
    - Visited bits are never cleared.
  - Else (sp=0, no move): found=0, go to FINISH.
- FINISH: done=1 for exactly one cycle, busy=0, return to IDLE.
  - found, path, path_len and cycles hold until the next accepted start.
  - On failure: path=0 and path_len=0.
- Stack depth is COLS*ROWS-1 entries. Every push enters a new cell, so the stack cannot overflow; no overflow logic.
- Latency: start sampled at edge N; CHECK at N+1; EXPLORE cycles follow; done is high in the cycle after the last EXPLORE cycle.
- maze and coordinate changes while busy are ignored (latched copies are used).
- start while busy is ignored.
- rst_n asserted mid-solve aborts immediately to reset values; no done pulse.

Test Plan:
- 3x3 all open (maze=9'h1FF), (0,0)->(2,2) -> moves R,R,D,D.
  - Required: path=9'h127, path_len=5, cycles=5, found=1.
  - done high 1 cycle, 7 cycles after start sampled.
- 3x3 maze=9'h1CB, (0,0)->(2,2) -> R into dead end (1,0), backtrack, then D,D,R,R.
  - Required: path=9'h1C9, path_len=5, cycles=7, found=1, bit1 cleared.
- 3x3 maze=9'h0FF (goal walled) -> fail in CHECK.
  - Required: done 2 cycles after start, found=0, path=0, path_len=0, cycles=0.
- 3x3 maze=9'h1F5 (start boxed in), (0,0)->(2,2).
  - Required: found=0, cycles=1, path=0.
- start_x=start_y=end_x=end_y=1, open cell.
  - Required: found=1, path=9'h010, path_len=1, cycles=0.
- 17x17 all open, (0,0)->(16,16); pulse start again while busy; repeat with rst_n low mid-solve.
  - Required: second start ignored; path_len=33, cycles=33.
  - After reset: all outputs 0, IDLE, no done pulse.
